// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and helpers for the clock display path
package clock_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SET_HH = 2'd1,
    SET_MM = 2'd2
  } mode_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  // Elaboration-time conversion of decimal parameters into BCD reset/limit values.
  function automatic bcd2_t to_bcd2(input int v);
    bcd2_t r;
    r.tens  = 4'(v / 10);
    r.units = 4'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_mod_cnt.sv
// rtl/bcd_mod_cnt.sv - two-digit BCD modulo counter with sync inc/clr
module bcd_mod_cnt
  import clock_pkg::*;
#(
  parameter int BASE = 60,
  parameter int INIT = 0
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  inc,
  input  logic  clr,
  output bcd2_t value,
  output logic  at_max
);

  localparam bcd2_t MAX_VAL  = to_bcd2(BASE - 1);
  localparam bcd2_t INIT_VAL = to_bcd2(INIT);

  assign at_max = (value == MAX_VAL);

  // Units roll 9->0 into tens; the field maximum wraps straight to 00.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      value <= INIT_VAL;
    end else if (clr || (inc && at_max)) begin
      value <= '0;
    end else if (inc) begin
      if (value.units == 4'd9) begin
        value.tens  <= value.tens + 4'd1;
        value.units <= 4'd0;
      end else begin
        value.units <= value.units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// rtl/clock_set_ctrl.sv - HH:MM:SS timekeeper with RUN/SET_HH/SET_MM mode FSM
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int HOUR_BASE = 24,
  parameter int MIN_BASE  = 60,
  parameter int SEC_BASE  = 60,
  parameter int INIT_HH   = 0,
  parameter int INIT_MM   = 0,
  parameter int INIT_SS   = 0
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic [1:0] mode,
  output logic       blink_hh,
  output logic       blink_mm,
  output logic       day_pulse
);

  mode_e state;
  logic  blink_phase;
  bcd2_t hh_val, mm_val, ss_val;
  logic  hh_max, mm_max, ss_max;
  logic  run_tick, set_inc;
  logic  hh_inc, mm_inc, ss_inc, ss_clr;

  // A mode press in the same cycle swallows btn_inc.
  assign run_tick = (state == RUN) && tick;
  assign set_inc  = btn_inc && !btn_mode;

  assign ss_inc = run_tick;
  assign mm_inc = (run_tick && ss_max) || ((state == SET_MM) && set_inc);
  assign hh_inc = (run_tick && ss_max && mm_max) || ((state == SET_HH) && set_inc);
  assign ss_clr = (state == SET_MM) && btn_mode;

  bcd_mod_cnt #(.BASE(SEC_BASE), .INIT(INIT_SS)) u_ss (
    .clk    (clk),
    .rstn   (rstn),
    .inc    (ss_inc),
    .clr    (ss_clr),
    .value  (ss_val),
    .at_max (ss_max)
  );

  bcd_mod_cnt #(.BASE(MIN_BASE), .INIT(INIT_MM)) u_mm (
    .clk    (clk),
    .rstn   (rstn),
    .inc    (mm_inc),
    .clr    (1'b0),
    .value  (mm_val),
    .at_max (mm_max)
  );

  bcd_mod_cnt #(.BASE(HOUR_BASE), .INIT(INIT_HH)) u_hh (
    .clk    (clk),
    .rstn   (rstn),
    .inc    (hh_inc),
    .clr    (1'b0),
    .value  (hh_val),
    .at_max (hh_max)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= RUN;
      blink_phase <= 1'b0;
      day_pulse   <= 1'b0;
    end else begin
      day_pulse <= run_tick && ss_max && mm_max && hh_max;
      case (state)
        RUN: begin
          if (btn_mode) begin
            state       <= SET_HH;
            blink_phase <= 1'b1;
          end
        end
        SET_HH: begin
          if (btn_mode) begin
            state       <= SET_MM;
            blink_phase <= 1'b1;
          end else if (tick) begin
            blink_phase <= !blink_phase;
          end
        end
        SET_MM: begin
          if (btn_mode) begin
            state       <= RUN;
            blink_phase <= 1'b0;
          end else if (tick) begin
            blink_phase <= !blink_phase;
          end
        end
        default: begin
          state       <= RUN;
          blink_phase <= 1'b0;
        end
      endcase
    end
  end

  assign hh       = hh_val;
  assign mm       = mm_val;
  assign ss       = ss_val;
  assign mode     = state;
  assign blink_hh = (state == SET_HH) && blink_phase;
  assign blink_mm = (state == SET_MM) && blink_phase;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb/tb_clock_set_ctrl.sv - directed and random checks of clock_set_ctrl against an integer model
module tb_clock_set_ctrl;

  localparam int HB = 24;
  localparam int MB = 60;
  localparam int SB = 60;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       tick = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hh, mm, ss;
  logic [1:0] mode;
  logic       blink_hh, blink_mm, day_pulse;

  int vectors = 0;
  int miscompares = 0;

  int m_h, m_m, m_s, m_mode;
  bit m_ph, m_day;

  clock_set_ctrl #(
    .HOUR_BASE (HB),
    .MIN_BASE  (MB),
    .SEC_BASE  (SB),
    .INIT_HH   (0),
    .INIT_MM   (0),
    .INIT_SS   (0)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .tick      (tick),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .hh        (hh),
    .mm        (mm),
    .ss        (ss),
    .mode      (mode),
    .blink_hh  (blink_hh),
    .blink_mm  (blink_mm),
    .day_pulse (day_pulse)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("hh", 24'(hh), 24'(bcd(m_h)));
    chk("mm", 24'(mm), 24'(bcd(m_m)));
    chk("ss", 24'(ss), 24'(bcd(m_s)));
    chk("mode", 24'(mode), 24'(m_mode));
    chk("blink_hh", 24'(blink_hh), 24'(m_mode == 1 && m_ph));
    chk("blink_mm", 24'(blink_mm), 24'(m_mode == 2 && m_ph));
    chk("day_pulse", 24'(day_pulse), 24'(m_day));
  endtask

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_ph = 0; m_day = 0;
  endtask

  task automatic model_step(input bit tk, input bit bm, input bit bi);
    m_day = 0;
    case (m_mode)
      0: begin
        if (tk) begin
          m_s++;
          if (m_s == SB) begin
            m_s = 0; m_m++;
            if (m_m == MB) begin
              m_m = 0; m_h++;
              if (m_h == HB) begin m_h = 0; m_day = 1; end
            end
          end
        end
        if (bm) begin m_mode = 1; m_ph = 1; end
      end
      1: begin
        if (bm) begin m_mode = 2; m_ph = 1; end
        else begin
          if (bi) m_h = (m_h + 1) % HB;
          if (tk) m_ph = !m_ph;
        end
      end
      default: begin
        if (bm) begin m_mode = 0; m_s = 0; m_ph = 0; end
        else begin
          if (bi) m_m = (m_m + 1) % MB;
          if (tk) m_ph = !m_ph;
        end
      end
    endcase
  endtask

  task automatic apply(input bit tk, input bit bm, input bit bi);
    @(negedge clk);
    tick = tk; btn_mode = bm; btn_inc = bi;
    @(posedge clk);
    model_step(tk, bm, bi);
    #1 check_model();
    tick = 0; btn_mode = 0; btn_inc = 0;
  endtask

  initial begin
    model_reset();
    #2 rstn = 1'b0;
    #1 check_model();
    @(posedge clk);
    #1 check_model();
    @(negedge clk);
    rstn = 1'b1;

    // 61 RUN ticks with idle gaps
    for (int i = 0; i < 61; i++) begin
      apply(1, 0, 0);
      repeat ($urandom_range(0, 2)) apply(0, 0, 0);
    end
    chk("t61_time", {hh, mm, ss}, 24'h000101);

    // set hours: 25 increments wrap 24 back round to 01, ticks frozen
    apply(0, 1, 0);
    for (int i = 0; i < 25; i++) apply(bit'($urandom_range(0, 1)), 0, 1);
    chk("set_hh_time", {hh, mm, ss}, 24'h010101);
    repeat (3) apply(1, 0, 0);

    // mode + inc collision in SET_HH
    apply(0, 1, 1);
    chk("collide_time", {hh, mm, ss}, 24'h010101);
    chk("collide_mode", 24'(mode), 24'd2);
    apply(0, 0, 1);

    // asynchronous reset mid SET_MM
    @(negedge clk);
    rstn = 1'b0;
    #1 model_reset();
    check_model();
    @(negedge clk);
    rstn = 1'b1;

    // set minutes from 00:00:37 and return with tick+mode collision
    repeat (37) apply(1, 0, 0);
    apply(0, 1, 0);
    apply(0, 1, 0);
    for (int i = 0; i < 61; i++) apply(bit'($urandom_range(0, 1)), 0, 1);
    chk("set_mm_time", {hh, mm, ss}, 24'h000137);
    apply(1, 1, 0);
    chk("return_time", {hh, mm, ss}, 24'h000100);
    chk("return_mode", 24'(mode), 24'd0);

    // midnight wrap
    apply(0, 1, 0);
    repeat (23) apply(0, 0, 1);
    apply(0, 1, 0);
    repeat (58) apply(0, 0, 1);
    apply(0, 1, 0);
    repeat (58) apply(1, 0, 0);
    chk("pre_midnight", {hh, mm, ss}, 24'h235958);
    apply(1, 0, 0);
    chk("last_second", {hh, mm, ss}, 24'h235959);
    apply(1, 0, 0);
    chk("midnight_time", {hh, mm, ss}, 24'h000000);
    chk("day_pulse_hi", 24'(day_pulse), 24'd1);
    apply(0, 0, 0);
    chk("day_pulse_lo", 24'(day_pulse), 24'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      apply(bit'($urandom_range(0, 99) < 30), bit'($urandom_range(0, 99) < 5),
            bit'($urandom_range(0, 99) < 30));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/clock_set_ctrl.md
# clock_set_ctrl

Timekeeping and time-setting controller for the digital-clock display path. It holds an HH:MM:SS time in two-digit BCD fields and advances it on a 1 Hz tick. It also runs a three-state mode FSM that lets the user set hours and minutes from two pulsed buttons. It sits between the tick generator and button conditioners on one side and the 7-segment display driver on the other.

## Interface
- `HOUR_BASE`, default 24: modulus of the hour field (≤ 100)
- `MIN_BASE`, default 60: modulus of the minute field (≤ 100)
- `SEC_BASE`, default 60: modulus of the second field (≤ 100)
- `INIT_HH` / `INIT_MM` / `INIT_SS`, default 0 / 0 / 0: decimal reset values, each < its base
- `clk`  in  1  clock. All logic on the posedge only.
- `rstn`  in  1  reset: asynchronous, active-low
- `tick`  in  1  1 Hz strobe, one clk cycle wide
- `btn_mode`  in  1  debounced mode-button pulse, one cycle wide
- `btn_inc`  in  1  debounced increment-button pulse, one cycle wide
- `hh`  out  8  hours, BCD `{tens,units}`
- `mm`  out  8  minutes, BCD
- `ss`  out  8  seconds, BCD
- `mode`  out  2  current FSM state code
- `blink_hh`  out  1  hour-field blank request for the display
- `blink_mm`  out  1  minute-field blank request
- `day_pulse`  out  1  one-cycle pulse on midnight wrap

## Operation
- **FSM states:** RUN (0), SET_HH (1), SET_MM (2).
  - `btn_mode` moves RUN→SET_HH→SET_MM→RUN.
  - Code 3 is unreachable and recovers to RUN on the next cycle.
- **RUN:**
  - `tick` increments `ss` mod SEC_BASE.
  - On the `ss` wrap, `mm` increments mod MIN_BASE. On the `mm` wrap, `hh` increments mod HOUR_BASE.
  - `btn_inc` is ignored.
- **SET_HH:**
  - `btn_inc` increments `hh` mod HOUR_BASE with no carry out.
  - `tick` does not advance time.
- **SET_MM:**
  - `btn_inc` increments `mm` mod MIN_BASE with no carry into `hh`.
  - `tick` does not advance time.
- **SET_MM→RUN transition:** clears `ss` to 00.
- **Blink:**
  - Internal `blink_phase` is set to 1 on entry to SET_HH or SET_MM and toggles on each `tick` while in a SET state.
  - `blink_hh` = (SET_HH & `blink_phase`); `blink_mm` = (SET_MM & `blink_phase`). Both are 0 in RUN.
- **Arithmetic:**
  - Each field is two BCD nibbles. Units wrap 9→0 with carry into tens.
  - A field is at maximum when its BCD value equals BASE−1. The next increment loads 00.
  - Nibbles never hold A–F.
- **day_pulse:** asserted when a RUN `tick` takes 23:59:59 (all fields at max) to 00:00:00.

## Timing
- **Reset values:** `hh`/`mm`/`ss` = BCD of INIT_*, `mode` = RUN, `blink_hh` = `blink_mm` = 0, `day_pulse` = 0, `blink_phase` = 0.
- **Latency:** all outputs are registered. An input strobe sampled at edge N is visible after edge N; there is no combinational input→output path.
- **Carry chain:** all three fields update on the same edge. There is no ripple delay across fields.
- **`day_pulse`:** high for exactly the cycle in which the outputs first read 00:00:00.
- **`btn_mode` and `btn_inc` in the same cycle:** the mode change wins and `btn_inc` is dropped.
- **`tick` and `btn_mode` in RUN, same cycle:** the tick is applied and the state moves to SET_HH.
- **`tick` and `btn_mode` in SET_MM, same cycle:** the state goes to RUN, `ss` = 00, and the tick is not counted.
- **`tick` and `btn_inc` in a SET state:** the increment is applied and `blink_phase` toggles.
- **Reset asserted mid-operation:** all state returns to its reset values immediately (asynchronously). No partial increment survives.
- **Strobe assumption:** back-to-back `btn_inc` pulses on consecutive cycles each count.

## Structure
- **Package `clock_pkg`:**
  - `mode_e` enum {RUN, SET_HH, SET_MM}, 2 bits
  - `bcd2_t` typedef (8-bit packed `{tens,units}`)
  - function `to_bcd2(int)` for parameter-to-reset conversion
- **Sub-module `bcd_mod_cnt #(BASE, INIT)`:**
  - Two-digit BCD mod-BASE counter: sync `inc`, sync `clr`, outputs `value` and combinational `at_max`.
  - Single posedge clock and async `rstn`.
  - Instantiated three times. The controller derives the `inc`/`clr` strobes from the FSM and the `at_max` flags.

## Test plan
- **Reset, then RUN ticks:** reset, then 61 ticks → time 00:01:01. `mode` = 0 throughout; `day_pulse` never high.
- **Midnight wrap:** reach 23:59:58, then 2 ticks → 23:59:59, then 00:00:00 with `day_pulse` = 1 for exactly one cycle.
- **Set hours:**
  - `btn_mode`, then 25 `btn_inc` pulses → `hh` = 01 and `mode` = 1. `mm` and `ss` are unchanged.
  - Ticks meanwhile do not move `ss`.
- **Set minutes and return:**
  - Starting at 00:00:37, `btn_mode` ×2, then 61 `btn_inc` → `mm` = 01 and `hh` unchanged.
  - Then `btn_mode` → `mode` = 0, `ss` = 00.
- **Blink:** in SET_HH, `blink_hh` = 1 on entry and toggles each tick (1,0,1…); `blink_mm` = 0. In RUN both are 0.
- **Collisions and reset:**
  - `btn_mode` + `btn_inc` in the same cycle in SET_HH → state SET_MM, `hh` unchanged.
  - `rstn` pulsed low mid-SET_MM → outputs return to INIT values and RUN before the next edge.
